ts_axi_sram_slave: RTL and testbench

// AXI4 slave backed by an internal word-addressed SRAM array. It is the downstream

---
 rtl/ts_axi_sram_slave.sv | 259 +++++++++++++++++++++++++
 tb/tb_ts_axi_sram_slave.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_axi_sram_slave.sv
// AXI4 slave over an internal word-addressed SRAM, one transaction at a time, write wins over read.
// Latency: B one cycle after the last W beat; R data two cycles after AR and 2 cycles per beat.
// Backpressure: B and R payloads are held stable until bready/rready; no AW/AR/W is taken outside its phase.
//
// Ports: clk/rst (async active-high); AW/W/B write channels and AR/R read channels (*_s_i / *_s_o).
// Optional build macro AXI_SRAM_STATS_EN adds wr_beats_o / rd_beats_o saturating beat counters.
// Responses: WRAP burst or size other than 4 bytes -> SLVERR; a beat outside the window -> DECERR.
module ts_axi_sram_slave #(
    parameter int          MEM_DEPTH = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          ID_W      = 4
) (
    input  logic            clk,
    input  logic            rst,
`ifdef AXI_SRAM_STATS_EN
    output logic [31:0]     wr_beats_o,
    output logic [31:0]     rd_beats_o,
`endif
    input  logic [ID_W-1:0] awid_s_i,
    input  logic [31:0]     awaddr_s_i,
    input  logic [7:0]      awlen_s_i,
    input  logic [2:0]      awsize_s_i,
    input  logic [1:0]      awburst_s_i,
    input  logic            awvalid_s_i,
    output logic            awready_s_o,
    input  logic [31:0]     wdata_s_i,
    input  logic [3:0]      wstrb_s_i,
    input  logic            wlast_s_i,
    input  logic            wvalid_s_i,
    output logic            wready_s_o,
    output logic [ID_W-1:0] bid_s_o,
    output logic [1:0]      bresp_s_o,
    output logic            bvalid_s_o,
    input  logic            bready_s_i,
    input  logic [ID_W-1:0] arid_s_i,
    input  logic [31:0]     araddr_s_i,
    input  logic [7:0]      arlen_s_i,
    input  logic [2:0]      arsize_s_i,
    input  logic [1:0]      arburst_s_i,
    input  logic            arvalid_s_i,
    output logic            arready_s_o,
    output logic [ID_W-1:0] rid_s_o,
    output logic [31:0]     rdata_s_o,
    output logic [1:0]      rresp_s_o,
    output logic            rlast_s_o,
    output logic            rvalid_s_o,
    input  logic            rready_s_i
);

    localparam int          IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [32:0] WIN_BYTES = 33'(MEM_DEPTH) * 33'd4;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_FETCH, RD_DATA} state_t;

    state_t           state, state_nxt;
    logic [ID_W-1:0]  id_q;
    logic [31:0]      addr_q;
    logic [7:0]       len_q;
    logic [7:0]       cnt_q;
    logic [1:0]       burst_q;
    logic             burst_err_q;  // WRAP or unsupported size: every beat errored
    logic             wlast_err_q;  // wlast disagreed with the beat count
    logic             dec_err_q;    // some write beat fell outside the window
    logic [31:0]      rdata_q;
    logic [1:0]       rresp_q;

    logic [31:0]      mem [MEM_DEPTH];

    logic [31:0]      off;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic [31:0]      addr_nxt;
    logic             last_beat;
    logic             aw_hs, ar_hs, w_hs, r_hs;
    logic             mem_we;

    // Offset is taken modulo 2^32, so addresses below BASE wrap to huge offsets and decode as out of window.
    assign off       = addr_q - BASE_ADDR;
    assign in_range  = {1'b0, off} < WIN_BYTES;
    assign idx       = off[IDX_W+1:2];
    assign addr_nxt  = (burst_q == BURST_FIXED) ? addr_q : addr_q + 32'd4;
    assign last_beat = (cnt_q == len_q);

    assign aw_hs  = awvalid_s_i & awready_s_o;
    assign ar_hs  = arvalid_s_i & arready_s_o;
    assign w_hs   = wvalid_s_i & wready_s_o;
    assign r_hs   = rvalid_s_o & rready_s_i;
    assign mem_we = w_hs & ~burst_err_q & in_range;

    assign bid_s_o   = id_q;
    assign rid_s_o   = id_q;
    assign rdata_s_o = rdata_q;
    assign rresp_s_o = rresp_q;
    assign bresp_s_o = (burst_err_q | wlast_err_q) ? RESP_SLVERR :
                       dec_err_q                   ? RESP_DECERR : RESP_OKAY;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake outputs are masked by rst so every output reads 0 while reset is held.
    always_comb begin
        state_nxt   = state;
        awready_s_o = 1'b0;
        arready_s_o = 1'b0;
        wready_s_o  = 1'b0;
        bvalid_s_o  = 1'b0;
        rvalid_s_o  = 1'b0;
        rlast_s_o   = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    awready_s_o = 1'b1;
                    arready_s_o = ~awvalid_s_i;
                    if (awvalid_s_i) begin
                        state_nxt = WR_DATA;
                    end else if (arvalid_s_i) begin
                        state_nxt = RD_FETCH;
                    end
                end
                WR_DATA: begin
                    wready_s_o = 1'b1;
                    // An early wlast ends the burst just like the final counted beat.
                    if (wvalid_s_i && (wlast_s_i || last_beat)) begin
                        state_nxt = WR_RESP;
                    end
                end
                WR_RESP: begin
                    bvalid_s_o = 1'b1;
                    if (bready_s_i) begin
                        state_nxt = IDLE;
                    end
                end
                RD_FETCH: begin
                    state_nxt = RD_DATA;
                end
                RD_DATA: begin
                    rvalid_s_o = 1'b1;
                    rlast_s_o  = last_beat;
                    if (rready_s_i) begin
                        state_nxt = last_beat ? IDLE : RD_FETCH;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            burst_q     <= '0;
            burst_err_q <= 1'b0;
            wlast_err_q <= 1'b0;
            dec_err_q   <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= '0;
        end else begin
            if (aw_hs) begin
                id_q        <= awid_s_i;
                addr_q      <= awaddr_s_i;
                len_q       <= awlen_s_i;
                burst_q     <= awburst_s_i;
                burst_err_q <= (awburst_s_i == BURST_WRAP) || (awsize_s_i != 3'b010);
                wlast_err_q <= 1'b0;
                dec_err_q   <= 1'b0;
                cnt_q       <= '0;
            end else if (ar_hs) begin
                id_q        <= arid_s_i;
                addr_q      <= araddr_s_i;
                len_q       <= arlen_s_i;
                burst_q     <= arburst_s_i;
                burst_err_q <= (arburst_s_i == BURST_WRAP) || (arsize_s_i != 3'b010);
                wlast_err_q <= 1'b0;
                dec_err_q   <= 1'b0;
                cnt_q       <= '0;
            end

            if (w_hs) begin
                addr_q <= addr_nxt;
                cnt_q  <= cnt_q + 8'd1;
                if (!in_range) begin
                    dec_err_q <= 1'b1;
                end
                if (wlast_s_i != last_beat) begin
                    wlast_err_q <= 1'b1;
                end
            end

            // Read data and response are captured once per beat and then held through rready stalls.
            if (state == RD_FETCH) begin
                if (burst_err_q) begin
                    rdata_q <= '0;
                    rresp_q <= RESP_SLVERR;
                end else if (!in_range) begin
                    rdata_q <= '0;
                    rresp_q <= RESP_DECERR;
                end else begin
                    rdata_q <= mem[idx];
                    rresp_q <= RESP_OKAY;
                end
            end

            if (r_hs && !last_beat) begin
                addr_q <= addr_nxt;
                cnt_q  <= cnt_q + 8'd1;
            end
        end
    end

    // SRAM array: no reset, contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_s_i[b]) begin
                    mem[idx][b*8 +: 8] <= wdata_s_i[b*8 +: 8];
                end
            end
        end
    end

`ifdef AXI_SRAM_STATS_EN
    logic [31:0] wr_cnt_q;
    logic [31:0] rd_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (w_hs && wr_cnt_q != 32'hFFFF_FFFF) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
            if (r_hs && rd_cnt_q != 32'hFFFF_FFFF) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    assign wr_beats_o = wr_cnt_q;
    assign rd_beats_o = rd_cnt_q;
`endif

endmodule

// File: tb/tb_ts_axi_sram_slave.sv
// Directed + randomized bench for ts_axi_sram_slave against a word/byte-level memory model.
// Latency: drives and samples one time unit after the falling edge, away from the active edge.
// Backpressure: exercises delayed bready and rready stalls and checks the held payloads.
module tb_ts_axi_sram_slave;

    localparam int          MEM_DEPTH = 1024;
    localparam logic [31:0] BASE      = 32'h1000_0000;
    localparam int          BUDGET    = 50;
    localparam logic [1:0]  FIXED     = 2'b00;
    localparam logic [1:0]  INCR      = 2'b01;
    localparam logic [1:0]  WRAP      = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = 3'b010;
    logic [1:0]  awburst = INCR;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'b010;
    logic [1:0]  arburst = INCR;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
`ifdef AXI_SRAM_STATS_EN
    logic [31:0] wr_beats;
    logic [31:0] rd_beats;
`endif

    int checks = 0;
    int errors = 0;
    int tb_wr  = 0;
    int tb_rd  = 0;

    // Reference model: word contents plus per-byte "known" flags.
    logic [31:0] mm  [MEM_DEPTH];
    logic [3:0]  knb [MEM_DEPTH];
    logic [31:0] wd  [256];
    logic [3:0]  ws  [256];
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    ts_axi_sram_slave #(.MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE), .ID_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef AXI_SRAM_STATS_EN
        .wr_beats_o (wr_beats),
        .rd_beats_o (rd_beats),
`endif
        .awid_s_i   (awid),
        .awaddr_s_i (awaddr),
        .awlen_s_i  (awlen),
        .awsize_s_i (awsize),
        .awburst_s_i(awburst),
        .awvalid_s_i(awvalid),
        .awready_s_o(awready),
        .wdata_s_i  (wdata),
        .wstrb_s_i  (wstrb),
        .wlast_s_i  (wlast),
        .wvalid_s_i (wvalid),
        .wready_s_o (wready),
        .bid_s_o    (bid),
        .bresp_s_o  (bresp),
        .bvalid_s_o (bvalid),
        .bready_s_i (bready),
        .arid_s_i   (arid),
        .araddr_s_i (araddr),
        .arlen_s_i  (arlen),
        .arsize_s_i (arsize),
        .arburst_s_i(arburst),
        .arvalid_s_i(arvalid),
        .arready_s_o(arready),
        .rid_s_o    (rid),
        .rdata_s_o  (rdata),
        .rresp_s_o  (rresp),
        .rlast_s_o  (rlast),
        .rvalid_s_o (rvalid),
        .rready_s_i (rready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic bit in_win(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return o < MEM_DEPTH * 4;
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] o;
        o = (a - BASE) >> 2;
        return int'(o);
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] b, input int i);
        return (b == FIXED) ? a : a + 32'(4 * i);
    endfunction

    function automatic bit burst_bad(input logic [1:0] b, input logic [2:0] s);
        return (b == WRAP) || (s != 3'b010);
    endfunction

    // Applies the first nbeats of wd/ws to the model and returns the response the slave must give.
    task automatic model_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                               input logic [2:0] size, input int nbeats, output logic [1:0] resp);
        bit se;
        bit dec;
        logic [31:0] a;
        int k;
        se  = burst_bad(burst, size);
        dec = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            a = beat_addr(addr, burst, i);
            if (!in_win(a)) begin
                dec = 1'b1;
            end else if (!se) begin
                k = widx(a);
                for (int b = 0; b < 4; b++) begin
                    if (ws[i][b]) begin
                        mm[k][b*8 +: 8] = wd[i][b*8 +: 8];
                        knb[k][b] = 1'b1;
                    end
                end
            end
        end
        resp = (se || nbeats != len + 1) ? 2'b10 : (dec ? 2'b11 : 2'b00);
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input logic [2:0] size);
        int n;
        awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awsize = size;
        awvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < BUDGET) begin step(); n++; end
        check("aw_wait", 64'(n < BUDGET), 64'd1);
        step();
        awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input logic [2:0] size);
        int n;
        arid = id; araddr = addr; arlen = 8'(len); arburst = burst; arsize = size;
        arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < BUDGET) begin step(); n++; end
        check("ar_wait", 64'(n < BUDGET), 64'd1);
        step();
        arvalid = 1'b0;
    endtask

    task automatic send_w(input int nbeats, input int last_at);
        int n;
        for (int i = 0; i < nbeats; i++) begin
            wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_at);
            wvalid = 1'b1;
            #1;
            n = 0;
            while (!wready && n < BUDGET) begin step(); n++; end
            check("w_wait", 64'(n < BUDGET), 64'd1);
            step();
            tb_wr++;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    // Entered right after the last W handshake: B must already be valid.
    task automatic recv_b(input logic [3:0] id, input logic [1:0] resp);
        int d;
        check("b_latency", 64'(bvalid), 64'd1);
        d = $urandom_range(0, 2);
        for (int k = 0; k < d; k++) begin
            step();
            check("b_hold", {bvalid, bid, bresp}, {1'b1, id, resp});
        end
        bready = 1'b1;
        check("bid", 64'(bid), 64'(id));
        check("bresp", 64'(bresp), 64'(resp));
        step();
        bready = 1'b0;
        check("b_done", 64'(bvalid), 64'd0);
    endtask

    task automatic recv_r(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [2:0] size, input int hold);
        int n;
        logic [31:0] a;
        logic [31:0] exp_d;
        logic [31:0] mask;
        logic [1:0]  exp_r;
        logic [38:0] snap;
        for (int i = 0; i <= len; i++) begin
            n = 0;
            while (!rvalid && n < BUDGET) begin step(); n++; end
            check("r_wait", 64'(n < BUDGET), 64'd1);
            if (n >= BUDGET) return;
            if (i == 0 && hold > 0) begin
                snap = {rdata, rresp, rlast, rid};
                for (int k = 0; k < hold; k++) begin
                    step();
                    check("r_hold", {rvalid, rdata, rresp, rlast, rid}, {1'b1, snap});
                end
            end
            a = beat_addr(addr, burst, i);
            if (burst_bad(burst, size)) begin
                exp_r = 2'b10; exp_d = '0; mask = '1;
            end else if (!in_win(a)) begin
                exp_r = 2'b11; exp_d = '0; mask = '1;
            end else begin
                exp_r = 2'b00;
                exp_d = mm[widx(a)];
                mask  = {{8{knb[widx(a)][3]}}, {8{knb[widx(a)][2]}},
                         {8{knb[widx(a)][1]}}, {8{knb[widx(a)][0]}}};
            end
            check("rresp", 64'(rresp), 64'(exp_r));
            check("rlast", 64'(rlast), 64'(i == len));
            check("rid", 64'(rid), 64'(id));
            if (mask != 0) check("rdata", 64'(rdata & mask), 64'(exp_d & mask));
            last_rdata = rdata;
            rready = 1'b1;
            step();
            rready = 1'b0;
            tb_rd++;
            check("r_gap", 64'(rvalid), 64'd0);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input logic [2:0] size, input int nbeats);
        logic [1:0] resp;
        model_write(addr, len, burst, size, nbeats, resp);
        send_aw(id, addr, len, burst, size);
        send_w(nbeats, nbeats - 1);
        recv_b(id, resp);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input logic [2:0] size, input int hold);
        send_ar(id, addr, len, burst, size);
        recv_r(id, addr, len, burst, size, hold);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] dummy;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            mm[i] = '0;
            knb[i] = '0;
        end

        // Reset state.
        step();
        check("reset_outputs", {awready, arready, wready, bvalid, bid, bresp, rvalid, rid, rdata, rresp, rlast}, 64'd0);
        rst = 1'b0;
        step();
        check("idle_ready", {awready, arready}, 2'b11);

        // INCR write A0..A3 then read it back.
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        do_write(4'h3, BASE, 3, INCR, 3'b010, 4);
        do_read(4'h9, BASE, 3, INCR, 3'b010, 0);

        // Simultaneous AW and AR: AW first, AR held off until B completes.
        wd[0] = 32'hCAFE_0001; ws[0] = 4'hF;
        model_write(BASE + 32'h20, 0, INCR, 3'b010, 1, dummy);
        arid = 4'h6; araddr = BASE + 32'h20; arlen = 8'd0; arburst = INCR; arsize = 3'b010;
        awid = 4'h5; awaddr = BASE + 32'h20; awlen = 8'd0; awburst = INCR; awsize = 3'b010;
        awvalid = 1'b1; arvalid = 1'b1;
        #1;
        check("aw_priority", {awready, arready}, 2'b10);
        step();
        awvalid = 1'b0;
        check("ar_blocked", 64'(arready), 64'd0);
        send_w(1, 0);
        recv_b(4'h5, dummy);
        check("ar_after_b", 64'(arready), 64'd1);
        step();
        arvalid = 1'b0;
        recv_r(4'h6, BASE + 32'h20, 0, INCR, 3'b010, 0);

        // Byte strobes.
        wd[0] = 32'h1234_5678; ws[0] = 4'hF;
        do_write(4'h1, BASE + 32'h40, 0, INCR, 3'b010, 1);
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'b0011;
        do_write(4'h1, BASE + 32'h40, 0, INCR, 3'b010, 1);
        do_read(4'h2, BASE + 32'h40, 0, INCR, 3'b010, 0);
        check("strobe_merge", 64'(last_rdata), 64'h1234_FFFF);

        // Window end: beat 0 written, beat 1 DECERR.
        wd[0] = 32'h5555_0000; wd[1] = 32'h5555_0001; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(4'h4, BASE + MEM_DEPTH * 4 - 4, 1, INCR, 3'b010, 2);
        do_read(4'h4, BASE + MEM_DEPTH * 4 - 4, 1, INCR, 3'b010, 0);

        // WRAP write is SLVERR and leaves memory unchanged.
        wd[0] = 32'h7777_7777; ws[0] = 4'hF;
        do_write(4'h7, BASE + 32'h80, 0, INCR, 3'b010, 1);
        wd[0] = 32'h8888_8888; wd[1] = 32'h9999_9999; ws[1] = 4'hF;
        do_write(4'h7, BASE + 32'h80, 1, WRAP, 3'b010, 2);
        do_read(4'h7, BASE + 32'h80, 0, INCR, 3'b010, 0);
        check("wrap_unchanged", 64'(last_rdata), 64'h7777_7777);

        // Early wlast on beat 1 of a 4-beat burst.
        wd[0] = 32'h0E0E_0000; wd[1] = 32'h0E0E_0001; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(4'hA, BASE + 32'hC0, 3, INCR, 3'b010, 2);

        // Reset in the middle of a write burst.
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hB0 + 32'(i); ws[i] = 4'hF; end
        do_write(4'h2, BASE + 32'h100, 3, INCR, 3'b010, 4);
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0 + 32'(i); ws[i] = 4'hF; end
        model_write(BASE + 32'h100, 3, INCR, 3'b010, 2, dummy);
        send_aw(4'h2, BASE + 32'h100, 3, INCR, 3'b010);
        send_w(2, 3);
        rst = 1'b1;
        step();
        check("midburst_reset", {awready, arready, wready, bvalid, bid, bresp, rvalid, rid, rdata, rresp, rlast}, 64'd0);
        rst = 1'b0;
        tb_wr = 0;
        tb_rd = 0;
        step();
        do_read(4'h2, BASE + 32'h100, 3, INCR, 3'b010, 0);
        check("reset_kept_old", 64'(last_rdata), 64'hB3);

        // Read stalled by rready for 5 cycles.
        do_read(4'hB, BASE, 3, INCR, 3'b010, 5);
`ifdef AXI_SRAM_STATS_EN
        check("rd_beats", 64'(rd_beats), 64'(tb_rd));
`endif

        // Randomized bursts, including FIXED and window-crossing ones.
        for (int t = 0; t < 12; t++) begin
            logic [31:0] a;
            logic [1:0]  b;
            logic [3:0]  id;
            int          len;
            len = $urandom_range(0, 7);
            b   = ($urandom_range(0, 3) == 0) ? FIXED : INCR;
            id  = 4'($urandom);
            if ($urandom_range(0, 4) == 0) a = BASE + 32'(4 * $urandom_range(MEM_DEPTH - 4, MEM_DEPTH - 1));
            else                           a = BASE + 32'(4 * $urandom_range(0, MEM_DEPTH - 8));
            for (int i = 0; i <= len; i++) begin
                wd[i] = $urandom;
                ws[i] = 4'($urandom_range(0, 15));
            end
            do_write(id, a, len, b, 3'b010, len + 1);
            do_read(id, a, len, b, 3'b010, $urandom_range(0, 2));
        end

`ifdef AXI_SRAM_STATS_EN
        check("wr_beats", 64'(wr_beats), 64'(tb_wr));
        check("rd_beats_end", 64'(rd_beats), 64'(tb_rd));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
